load_store_unit: RTL and testbench

//  CPU-side initiator for the word-wide data memory. Accepts one load/store
//  per request from the execute stage and drives req/ready cycles to memory.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory: extends sub-word loads, does SB/SH as read-modify-write.
// Optional build macro MISALIGN_TRAP_EN faults misaligned H/HU/SH/W/SW instead of silently aligning them.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_fault,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t                  state_q;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [1:0]              lane_q;
  logic [31:0]             wdata_q;
  logic [31:0]             cnt_q;
  logic                    ready_q, done_q, fault_q, mem_req_q, mem_we_q;
  logic [31:0]             rdata_q, mem_wdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;

  logic                    reject_d;
  logic                    timeout_hit_d;
  logic [31:0]             load_d;
  logic [31:0]             merge_d;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Only the addressed lane is replaced; the remaining lanes keep the word just read.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f, input logic [1:0] a);
    logic [31:0] mask;
    logic [31:0] data;
    if (f[0]) begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      data = {2{d[15:0]}};
    end else begin
      mask = 32'h0000_00FF << {a, 3'b000};
      data = {4{d[7:0]}};
    end
    return (w & ~mask) | (data & mask);
  endfunction

  always_comb begin
    reject_d = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if (i_funct3[1:0] == 2'b01)
      reject_d = reject_d || i_addr[0];
    else if (i_funct3[1:0] == 2'b10)
      reject_d = reject_d || (i_addr[1:0] != 2'b00);
`endif
  end

  assign timeout_hit_d = (TIMEOUT > 0) && (cnt_q == TO_LAST);
  assign load_d        = load_ext(i_mem_rdata, funct3_q, lane_q);
  assign merge_d       = store_merge(i_mem_rdata, wdata_q, funct3_q, lane_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= 32'd0;
      cnt_q       <= 32'd0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            we_q     <= i_we;
            funct3_q <= i_funct3;
            lane_q   <= i_addr[1:0];
            wdata_q  <= i_wdata;
            cnt_q    <= 32'd0;
            ready_q  <= 1'b0;
            if (reject_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              if (i_we && (i_funct3[1:0] == 2'b10)) begin
                state_q     <= S_WR;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= i_wdata;
              end else begin
                state_q  <= S_RD;
                mem_we_q <= 1'b0;
              end
            end
          end
        end
        S_RD: begin
          if (i_mem_ready) begin
            cnt_q <= 32'd0;
            if (we_q) begin
              state_q     <= S_WR;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merge_d;
            end else begin
              state_q   <= S_DONE;
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
              rdata_q   <= load_d;
            end
          end else if (timeout_hit_d) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= 1'b1;
            rdata_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_WR: begin
          if (i_mem_ready || timeout_hit_d) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            fault_q   <= !i_mem_ready;
            rdata_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_fault     = fault_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-memory model, load extension, RMW stores, stalls, timeout, reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mready = 1'b0;
  logic [31:0] mrdata;
  logic        ready, done, fault, mreq, mwe;
  logic [31:0] rdata, maddr, mwdata;

  logic [31:0] mem [0:31];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;

  int          n_asserts = 0;
  int          n_fail = 0;

  int          lat, reqc, r0, w0;
  logic [31:0] rd;
  logic        flt, stable;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_ready(ready), .o_done(done), .o_rdata(rdata),
    .o_fault(fault), .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr),
    .o_mem_wdata(mwdata), .i_mem_ready(mready), .i_mem_rdata(mrdata)
  );

  assign mrdata = mem[maddr[6:2]];

  // Memory model: preloaded while reset is asserted, commits writes on ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h1122_3344;
      mem[1] <= 32'h8091_A2B3;
    end else if (mreq && mready) begin
      if (mwe) begin
        mem[maddr[6:2]] <= mwdata;
        wr_cnt  <= wr_cnt + 1;
        last_wa <= maddr;
        last_wd <= mwdata;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output int l, output logic [31:0] r,
                        output logic fl);
    @(negedge clk);
    valid = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(posedge clk);
    l = 1;
    @(negedge clk);
    valid = 1'b0;
    while (!done && l < 40) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    r  = rdata;
    fl = fault;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ctl", {28'd0, done, fault, mreq, mwe}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwdata", mwdata, 32'd0);
    rst_n = 1'b1;
    mready = 1'b1;

    do_req(1'b0, 3'b000, 32'h5, 32'd0, lat, rd, flt);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_rdata", rd, 32'hFFFF_FFA2);
    chk("lb_fault", {31'd0, flt}, 32'd0);
    do_req(1'b0, 3'b101, 32'h6, 32'd0, lat, rd, flt);
    chk("lhu_rdata", rd, 32'h0000_8091);
    do_req(1'b0, 3'b001, 32'h6, 32'd0, lat, rd, flt);
    chk("lh_rdata", rd, 32'hFFFF_8091);
    do_req(1'b0, 3'b100, 32'h7, 32'd0, lat, rd, flt);
    chk("lbu_rdata", rd, 32'h0000_0080);
    do_req(1'b0, 3'b010, 32'h4, 32'd0, lat, rd, flt);
    chk("lw_rdata", rd, 32'h8091_A2B3);
    chk("lw_lat", 32'(lat), 32'd2);

    r0 = rd_cnt; w0 = wr_cnt;
    do_req(1'b1, 3'b000, 32'h7, 32'h0000_00CC, lat, rd, flt);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_reads", 32'(rd_cnt - r0), 32'd1);
    chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sb_wdata", last_wd, 32'hCC91_A2B3);
    chk("sb_waddr", last_wa, 32'h4);
    do_req(1'b1, 3'b001, 32'h6, 32'hFFFF_5678, lat, rd, flt);
    chk("sh_wdata", last_wd, 32'h5678_A2B3);
    chk("sh_fault", {31'd0, flt}, 32'd0);
    do_req(1'b0, 3'b010, 32'h4, 32'd0, lat, rd, flt);
    chk("lw_after_sh", rd, 32'h5678_A2B3);

    mready = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stable &= (mreq === 1'b1) && (mwe === 1'b1) && (maddr === 32'h10) &&
                (mwdata === 32'hDEAD_BEEF) && (ready === 1'b0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    stable &= (mreq === 1'b1) && (maddr === 32'h10) && (mwdata === 32'hDEAD_BEEF);
    chk("sw_stall_stable", {31'd0, stable}, 32'd1);
    chk("sw_no_early_write", 32'(wr_cnt - w0), 32'd0);
    mready = 1'b1;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("sw_lat", 32'(lat), 32'd7);
    chk("sw_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sw_wdata", last_wd, 32'hDEAD_BEEF);
    chk("sw_waddr", last_wa, 32'h10);

    mready = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'h55;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    valid = 1'b0;
    reqc = 0;
    while (!done && lat < 40) begin
      if (mreq) reqc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(reqc), 32'd8);
    chk("to_lat", 32'(lat), 32'd9);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_req_low", {31'd0, mreq}, 32'd0);
    chk("to_no_write", 32'(wr_cnt - w0), 32'd0);
    @(negedge clk);
    chk("to_ready_again", {31'd0, ready}, 32'd1);
    mready = 1'b1;

    r0 = rd_cnt;
    do_req(1'b0, 3'b110, 32'h4, 32'd0, lat, rd, flt);
    chk("badf3_fault", {31'd0, flt}, 32'd1);
    chk("badf3_lat", 32'(lat), 32'd1);
    chk("badf3_no_read", 32'(rd_cnt - r0), 32'd0);

    r0 = rd_cnt;
    do_req(1'b0, 3'b010, 32'h2, 32'd0, lat, rd, flt);
`ifdef MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, flt}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_no_read", 32'(rd_cnt - r0), 32'd0);
`else
    chk("mis_fault", {31'd0, flt}, 32'd0);
    chk("mis_rdata", rd, 32'h1122_3344);
    chk("mis_lat", 32'(lat), 32'd2);
`endif

    mready = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    valid = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h5; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("rd_req_high", {31'd0, mreq}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_low", {31'd0, mreq}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    mready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_no_write", 32'(wr_cnt - w0), 32'd0);
    do_req(1'b0, 3'b010, 32'h4, 32'd0, lat, rd, flt);
    chk("post_rst_lw", rd, 32'h8091_A2B3);
    chk("post_rst_lat", 32'(lat), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
